uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_picker.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared state encoding and payload width for the UART TX arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_START     = 2'b01,
        ST_WAIT_DONE = 2'b10,
        ST_GUARD     = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin pick: first set request at or above ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [GID_W-1:0]   grant_idx,
    output logic               any
);

    int w_j;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr never exceeds NUM_REQ-1, so one subtraction wraps the scan
            w_j = int'(ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!any && req[w_j]) begin
                any           = 1'b1;
                grant_idx     = GID_W'(w_j);
                grant_oh[w_j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin sharing of one UART transmitter between byte sources.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GID_W      = 2,
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [GID_W-1:0]               grant_id,
    output logic                           active,
    output logic                           err_timeout
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GID_W-1:0] C_LAST_ID  = GID_W'(NUM_REQ - 1);

    state_e                 state_q, state_d;
    logic [GID_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tx_start_q, tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [GID_W-1:0]       grant_q, grant_d;
    logic                   active_q, active_d;
    logic                   err_q, err_d;

    logic [NUM_REQ-1:0]     w_grant_oh;
    logic [GID_W-1:0]       w_win_idx;
    logic                   w_any;
    logic                   w_accept;
    logic [UART_DATA_W-1:0] w_payload;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GID_W   (GID_W)
    ) u_rr_picker (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_oh  (w_grant_oh),
        .grant_idx (w_win_idx),
        .any       (w_any)
    );

    // A reset cycle never shows ready, so no source believes it handed off a byte
    assign w_accept  = (state_q == ST_IDLE) && w_any && !tx_busy && !reset;
    assign req_ready = w_accept ? w_grant_oh : '0;
    assign w_payload = req_data[int'(w_win_idx)*UART_DATA_W +: UART_DATA_W];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    tx_data_d  = w_payload;
                    grant_d    = w_win_idx;
                    ptr_d      = (w_win_idx == C_LAST_ID) ? '0 : w_win_idx + GID_W'(1);
                    cnt_d      = '0;
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                // busy takes priority so an ack on the last allowed cycle is a success
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end else if (cnt_q == C_TO_LAST) begin
                    tx_start_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = C_GAP_LOAD;
                        state_d = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            active_q   <= active_d;
            err_q      <= err_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Self-checking bench with transmitter model and frame-level reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GW  = 2;
    localparam int TO  = 16;
    localparam int GAP = 2;
    localparam int DW  = 7;

    localparam int PH_IDLE  = 0;
    localparam int PH_START = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_GUARD = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [DW*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic [GW-1:0]   grant_id;
    logic            active;
    logic            err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .GID_W      (GW),
        .TIMEOUT    (TO),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Transmitter model: busy rises tx_dly cycles after it sees start, for tx_len cycles
    bit tx_never = 0, tx_force = 0, tx_frame_busy = 0, tx_on = 0;
    int tx_dly = 0, tx_len = 4, tx_dl = 0, tx_ll = 0;
    assign tx_busy = tx_force | tx_frame_busy;

    // Reference model of the arbiter, one frame phase at a time
    int           m_phase = PH_IDLE, m_ptr = 0, m_grant = 0, m_wait = 0, m_gap = 0;
    logic [DW-1:0] m_data = '0;
    bit           m_err = 0;

    function automatic int m_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(input logic [N-1:0] v, input bit b, input bit r);
        int w;
        if (r || b || m_phase != PH_IDLE) return '0;
        w = m_winner(v);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] v, input logic [DW*N-1:0] d, input bit b);
        int w;
        if (r) begin
            m_phase = PH_IDLE; m_ptr = 0; m_grant = 0; m_data = '0;
            m_err = 0; m_wait = 0; m_gap = 0;
            return;
        end
        case (m_phase)
            PH_IDLE: if (!b) begin
                w = m_winner(v);
                if (w >= 0) begin
                    m_data  = d[DW*w +: DW];
                    m_grant = w;
                    m_ptr   = (w + 1) % N;
                    m_wait  = 0;
                    m_phase = PH_START;
                end
            end
            PH_START: begin
                if (b) m_phase = PH_WAIT;
                else if (m_wait == TO - 1) begin m_err = 1; m_phase = PH_IDLE; end
                else m_wait++;
            end
            PH_WAIT: if (!b) begin
                if (GAP == 0) m_phase = PH_IDLE;
                else begin m_gap = GAP; m_phase = PH_GUARD; end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_phase = PH_IDLE;
            end
        endcase
    endtask

    logic [N-1:0] acc_vec;
    int           acc_idx;
    bit           last_b;

    task automatic tick();
        logic [N-1:0]    v, rdy;
        logic [DW*N-1:0] d;
        bit              r;
        #1;
        rdy = req_ready;
        check("req_ready", rdy, m_ready(req_valid, tx_busy, rst));
        v = req_valid; d = req_data; r = rst; last_b = tx_busy;
        acc_vec = v & rdy;
        acc_idx = -1;
        for (int i = 0; i < N; i++) if (acc_vec[i]) acc_idx = i;
        @(posedge clk);
        #1;
        model_step(r, v, d, last_b);
        check("tx_start", tx_start, m_phase == PH_START);
        check("active", active, m_phase != PH_IDLE);
        check("tx_data", tx_data, m_data);
        check("grant_id", grant_id, m_grant);
        check("err_timeout", err_timeout, m_err);
        if (r) begin
            tx_on = 0; tx_frame_busy = 0;
        end else begin
            if (!tx_on && tx_start && !tx_never) begin
                tx_on = 1; tx_dl = tx_dly; tx_ll = tx_len;
            end
            if (tx_on) begin
                if (tx_dl > 0) tx_dl--;
                else if (tx_ll > 0) begin tx_frame_busy = 1; tx_ll--; end
                else begin tx_frame_busy = 0; tx_on = 0; end
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1; req_valid = '0; tx_force = 0; tx_never = 0;
        repeat (cycles) tick();
        rst = 0;
    endtask

    task automatic wait_accept(input string tag, input int max, output int idx);
        bit seen = 0;
        idx = -1;
        for (int c = 0; c < max && !seen; c++) begin
            tick();
            if (acc_vec != '0) begin seen = 1; idx = acc_idx; end
        end
        check(tag, seen, 1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        bit idle = 0;
        for (int c = 0; c < max && !idle; c++) begin
            tick();
            if (!active) idle = 1;
        end
        check(tag, idle, 1);
    endtask

    initial begin
        int idx, cnt, gap;
        bit seen, done;
        int order[$];

        // 1: reset values and quiet idle
        tx_dly = 0; tx_len = 4;
        do_reset(3);
        check("rst_tx_start", tx_start, 0);
        check("rst_active", active, 0);
        check("rst_grant", grant_id, 0);
        check("rst_err", err_timeout, 0);
        cnt = 0;
        repeat (20) begin tick(); if (tx_start) cnt++; end
        check("idle_no_start", cnt, 0);

        // 2: single source, 10-cycle frame, two guard cycles
        tx_len = 10;
        req_data[DW*2 +: DW] = 7'h55;
        req_valid = 4'b0100;
        wait_accept("s2_accept", 10, idx);
        req_valid = '0;
        check("s2_idx", idx, 2);
        check("s2_start_next", tx_start, 1);
        check("s2_data", tx_data, 7'h55);
        check("s2_grant", grant_id, 2);
        seen = 0; done = 0; gap = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (last_b) seen = 1;
            else if (seen) begin
                if (active) gap++;
                else done = 1;
            end
        end
        check("s2_guard_cycles", gap, GAP);

        // 3: all valid, rotation 0,1,2,3,0
        do_reset(2);
        tx_len = 3;
        for (int i = 0; i < N; i++) req_data[DW*i +: DW] = DW'(7'h10 + i);
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_accept("s3_accept", 40, idx);
            order.push_back(idx);
            check("s3_frame_data", tx_data, 7'h10 + idx);
        end
        req_valid = '0;
        check("s3_order0", order[0], 0);
        check("s3_order1", order[1], 1);
        check("s3_order2", order[2], 2);
        check("s3_order3", order[3], 3);
        check("s3_order4", order[4], 0);
        wait_idle("s3_idle", 40);

        // 4: transmitter never acknowledges
        do_reset(2);
        tx_never = 1;
        req_valid = 4'b0001;
        wait_accept("s4_accept", 10, idx);
        req_valid = '0;
        cnt = (tx_start) ? 1 : 0;
        repeat (30) begin tick(); if (tx_start) cnt++; end
        check("s4_start_cycles", cnt, TO);
        check("s4_err", err_timeout, 1);
        check("s4_idle", active, 0);
        tx_never = 0;
        req_valid = 4'b0010;
        wait_accept("s4_accept2", 10, idx);
        req_valid = '0;
        check("s4_idx2", idx, 1);
        wait_idle("s4_idle2", 40);
        check("s4_err_sticky", err_timeout, 1);

        // 5: stale busy in idle blocks every grant
        do_reset(2);
        tx_force = 1;
        req_valid = 4'b1111;
        repeat (6) begin tick(); check("s5_no_ready", acc_vec, 0); end
        tx_force = 0;
        wait_accept("s5_accept", 5, idx);
        req_valid = '0;
        check("s5_first", idx, 0);
        wait_idle("s5_idle", 40);

        // 6: reset during WAIT_DONE
        do_reset(2);
        tx_len = 8;
        req_valid = 4'b0100;
        wait_accept("s6_accept", 10, idx);
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin tick(); if (tx_busy) seen = 1; end
        check("s6_busy_seen", seen, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("s6_active", active, 0);
        check("s6_tx_start", tx_start, 0);
        req_valid = 4'b0110;
        wait_accept("s6_accept2", 5, idx);
        req_valid = '0;
        check("s6_lowest", idx, 1);

        // Randomized traffic, including timeout boundary delays and stray resets
        do_reset(2);
        for (int c = 0; c < 1500; c++) begin
            req_valid = N'($urandom);
            req_data  = (DW*N)'({$urandom, $urandom});
            tx_never  = ($urandom_range(0, 40) == 0);
            tx_dly    = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            tx_len    = $urandom_range(1, 8);
            rst       = ($urandom_range(0, 120) == 0);
            tick();
        end
        rst = 0;
        req_valid = '0;
        tx_never = 0;
        wait_idle("rand_drain", 80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
